uart_frame_ctrl: RTL and testbench
==================================

// Module: uart_frame_ctrl
// PURPOSE
//  Frame controller sequencing the UART receive byte stream into commands for the AGV core.
//  Consumes the byte strobe from the RX deserialiser and hunts for start-of-frame (SOF).
//  Parses the frame SOF,CMD,LEN,PAYLOAD[LEN],CHK and buffers the payload.
//  Presents each checksum-good command on a valid/ready port; counts error events.
// PARAMETERS
//  SOF          8'hAA  start-of-frame byte
//  MAX_LEN      16     max payload bytes (>=2); LW=$clog2(MAX_LEN+1), AW=$clog2(MAX_LEN)
//  TIMEOUT_CYC  3500   max clk cycles between bytes inside a frame (~4 byte times at 87 clk/bit)
//  CNT_W        8      width of each error counter
// PORTS
//  clk          in   1      system clock, all logic on rising edge
//  reset_n      in   1      asynchronous, active-low reset
//  en           in   1      parser enable; low aborts an in-progress frame
//  rx_byte      in   8      received byte; valid only when rx_valid=1
//  rx_valid     in   1      one-cycle strobe, one per received byte
//  cmd_valid    out  1      command available; held until accepted
//  cmd_ready    in   1      consumer accepts command when cmd_valid&&cmd_ready
//  cmd_id       out  8      CMD byte of held frame
//  cmd_len      out  LW     payload length of held frame
//  pl_raddr     in   AW     payload buffer read address
//  pl_rdata     out  8      payload[pl_raddr], combinational read
//  busy         out  1      1 when state != IDLE
//  clr_err      in   1      synchronous clear of all error counters
//  err_chk_cnt  out  CNT_W  checksum failures, saturating
//  err_len_cnt  out  CNT_W  LEN > MAX_LEN events, saturating
//  err_tmo_cnt  out  CNT_W  inter-byte timeouts, saturating
//  err_ovr_cnt  out  CNT_W  bytes dropped while in HOLD, saturating
// BEHAVIOUR
//  Reset: state=IDLE; cmd_valid=0, cmd_id=0, cmd_len=0, busy=0, all counters=0, buffer=0.
//  Bytes are consumed only on cycles with rx_valid=1. All state transitions are registered.
//  States and transitions:
//   IDLE: rx_valid && en && byte==SOF -> CMD. Any other byte is ignored and is not an error.
//   CMD:  on byte, cmd_id<=byte; chk<=byte -> LEN.
//   LEN:  byte>MAX_LEN (full 8-bit compare): err_len+1 -> IDLE.
//         byte==0 -> CHK.
//         otherwise -> DATA. On both non-error paths: cmd_len<=byte, chk^=byte, idx<=0.
//   DATA: buf[idx]<=byte; chk^=byte; idx+1. After byte number cmd_len -> CHK.
//   CHK:  byte==chk -> HOLD. Mismatch: err_chk+1 -> IDLE.
//   HOLD: cmd_valid=1; cmd_id, cmd_len and the buffer are frozen.
//         cmd_valid&&cmd_ready -> IDLE; cmd_valid drops on the next cycle.
//  Latency: cmd_valid rises 1 clk after the rx_valid cycle that carries a good CHK byte.
//  chk = XOR of CMD, LEN and all payload bytes (SOF excluded).
//  Timeout:
//   - Counter runs only in CMD/LEN/DATA/CHK and clears on every rx_valid.
//   - Reaching TIMEOUT_CYC-1 -> IDLE, err_tmo+1.
//   - rx_valid in the same cycle as expiry: the byte wins and no timeout occurs.
//  HOLD overrun:
//   - Each rx_valid in HOLD drops the byte and adds err_ovr+1, including in the handshake cycle.
//   - A dropped SOF does not start a frame.
//  en=0:
//   - In CMD/LEN/DATA/CHK: -> IDLE next edge, no error count, buffer contents don't care.
//   - In IDLE: SOF ignored.
//   - In HOLD: no effect; the command is still delivered.
//  Counters: saturate at 2^CNT_W-1. clr_err zeroes all four; clr_err wins over a same-cycle increment.
//  pl_rdata for pl_raddr >= cmd_len: content unspecified. Buffer is valid only while cmd_valid=1.
//  Reset asserted mid-frame or in HOLD: immediate return to reset values; partial frame is discarded.
// STRUCTURE
//  Package uart_frame_pkg: state enum (IDLE,CMD,LEN,DATA,CHK,HOLD), default SOF, MAX_LEN, CNT_W.
//  Sub-module sat_counter (CNT_W, inc, clr, cnt), instantiated 4x for the error counters.
//  Payload buffer: flat reg array inside the top module, no RAM macro.
// TESTING
//  1. Good frame AA 10 03 01 02 04 CHK=14 -> cmd_valid 1 clk after CHK byte; cmd_id=10, cmd_len=3,
//     buf[0..2]=01,02,04; ready pulse -> IDLE.
//  2. Zero-length frame AA 5A 00 5A -> cmd_valid, cmd_len=0. Bad CHK AA 5A 00 00 -> err_chk_cnt=1,
//     no cmd_valid.
//  3. Length and noise: AA 01 11 (LEN=17 > 16) -> err_len_cnt=1, IDLE.
//     Then 00 AA 10 00 10 -> command delivered.
//  4. Timeout: AA 10, then idle 3500 clk -> err_tmo_cnt=1, busy=0.
//     Byte arriving exactly at expiry -> no timeout.
//  5. Overrun: hold cmd_ready=0, send 3 bytes -> err_ovr_cnt=3, cmd_id unchanged.
//     Saturation at 255 with CNT_W=8; clr_err together with increment -> 0.
//  6. en dropped in DATA -> IDLE, no counters move. reset_n pulsed in HOLD -> cmd_valid=0 immediately.

Source files
------------

// File: rtl/uart_frame_pkg.sv
// Shared types and defaults for the UART frame controller.
// The error counter indices select entries of the counter array in the top.
package uart_frame_pkg;
    localparam logic [7:0] SOF_DEF     = 8'hAA;
    localparam int         MAX_LEN_DEF = 16;
    localparam int         TMO_DEF     = 3500;
    localparam int         CNT_W_DEF   = 8;

    localparam int NUM_ERR = 4;
    localparam int ERR_CHK = 0;
    localparam int ERR_LEN = 1;
    localparam int ERR_TMO = 2;
    localparam int ERR_OVR = 3;

    typedef enum logic [2:0] {IDLE, CMD, LEN, DATA, CHK, HOLD} state_e;
endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear.
// A clear in the same cycle as an increment leaves the counter at zero.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (inc && (cnt_q != '1))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/uart_frame_ctrl.sv
// Parses SOF,CMD,LEN,PAYLOAD,CHK frames from the RX byte strobe and holds each
// checksum-good command on a valid/ready port, counting framing errors.
module uart_frame_ctrl
    import uart_frame_pkg::*;
#(
    parameter logic [7:0] SOF         = SOF_DEF,
    parameter int         MAX_LEN     = MAX_LEN_DEF,
    parameter int         TIMEOUT_CYC = TMO_DEF,
    parameter int         CNT_W       = CNT_W_DEF,
    localparam int        LW          = $clog2(MAX_LEN + 1),
    localparam int        AW          = $clog2(MAX_LEN)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [7:0]       rx_byte,
    input  logic             rx_valid,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic [7:0]       cmd_id,
    output logic [LW-1:0]    cmd_len,
    input  logic [AW-1:0]    pl_raddr,
    output logic [7:0]       pl_rdata,
    output logic             busy,
    input  logic             clr_err,
    output logic [CNT_W-1:0] err_chk_cnt,
    output logic [CNT_W-1:0] err_len_cnt,
    output logic [CNT_W-1:0] err_tmo_cnt,
    output logic [CNT_W-1:0] err_ovr_cnt
);
    localparam int TW = $clog2(TIMEOUT_CYC);

    state_e                    state_q, state_d;
    logic [7:0]                cmd_id_q, cmd_id_d;
    logic [7:0]                chk_q, chk_d;
    logic [LW-1:0]             cmd_len_q, cmd_len_d;
    logic [AW-1:0]             idx_q, idx_d;
    logic [TW-1:0]             tmo_q, tmo_d;
    logic [MAX_LEN-1:0][7:0]   buf_q, buf_d;
    logic [NUM_ERR-1:0]        err_inc;
    logic [NUM_ERR-1:0][CNT_W-1:0] err_cnt;

    always_comb begin
        state_d   = state_q;
        cmd_id_d  = cmd_id_q;
        chk_d     = chk_q;
        cmd_len_d = cmd_len_q;
        idx_d     = idx_q;
        buf_d     = buf_q;
        tmo_d     = '0;
        err_inc   = '0;
        unique case (state_q)
            IDLE: if (rx_valid && en && (rx_byte == SOF)) state_d = CMD;
            CMD, LEN, DATA, CHK: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (rx_valid) begin
                    case (state_q)
                        CMD: begin
                            cmd_id_d = rx_byte;
                            chk_d    = rx_byte;
                            state_d  = LEN;
                        end
                        LEN: begin
                            if (32'(rx_byte) > MAX_LEN) begin
                                err_inc[ERR_LEN] = 1'b1;
                                state_d          = IDLE;
                            end else begin
                                cmd_len_d = LW'(rx_byte);
                                chk_d     = chk_q ^ rx_byte;
                                idx_d     = '0;
                                state_d   = (rx_byte == 8'd0) ? CHK : DATA;
                            end
                        end
                        DATA: begin
                            buf_d[idx_q] = rx_byte;
                            chk_d        = chk_q ^ rx_byte;
                            idx_d        = idx_q + 1'b1;
                            if ((LW'(idx_q) + 1'b1) == cmd_len_q) state_d = CHK;
                        end
                        CHK: begin
                            if (rx_byte == chk_q) begin
                                state_d = HOLD;
                            end else begin
                                err_inc[ERR_CHK] = 1'b1;
                                state_d          = IDLE;
                            end
                        end
                        default: ;
                    endcase
                end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                    // a byte landing on the expiry cycle takes the branch above instead
                    err_inc[ERR_TMO] = 1'b1;
                    state_d          = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            HOLD: begin
                if (rx_valid)  err_inc[ERR_OVR] = 1'b1;
                if (cmd_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cmd_id_q  <= '0;
            chk_q     <= '0;
            cmd_len_q <= '0;
            idx_q     <= '0;
            tmo_q     <= '0;
            buf_q     <= '0;
        end else begin
            state_q   <= state_d;
            cmd_id_q  <= cmd_id_d;
            chk_q     <= chk_d;
            cmd_len_q <= cmd_len_d;
            idx_q     <= idx_d;
            tmo_q     <= tmo_d;
            buf_q     <= buf_d;
        end
    end

    for (genvar g = 0; g < NUM_ERR; g++) begin : g_err
        sat_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk    (clk),
            .reset_n(reset_n),
            .inc    (err_inc[g]),
            .clr    (clr_err),
            .cnt    (err_cnt[g])
        );
    end

    assign cmd_valid   = (state_q == HOLD);
    assign busy        = (state_q != IDLE);
    assign cmd_id      = cmd_id_q;
    assign cmd_len     = cmd_len_q;
    assign pl_rdata    = buf_q[pl_raddr];
    assign err_chk_cnt = err_cnt[ERR_CHK];
    assign err_len_cnt = err_cnt[ERR_LEN];
    assign err_tmo_cnt = err_cnt[ERR_TMO];
    assign err_ovr_cnt = err_cnt[ERR_OVR];
endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Directed bench for uart_frame_ctrl: a frame-level reference model checked every
// cycle, plus hand-computed expectations at key points of each scenario.
module tb_uart_frame_ctrl;
    logic       clk = 1'b0;
    logic       reset_n, en, rx_valid, cmd_ready, clr_err;
    logic [7:0] rx_byte;
    logic [3:0] pl_raddr;
    logic       cmd_valid, busy;
    logic [7:0] cmd_id, pl_rdata;
    logic [4:0] cmd_len;
    logic [7:0] err_chk_cnt, err_len_cnt, err_tmo_cnt, err_ovr_cnt;

    int total = 0;
    int bad   = 0;

    uart_frame_ctrl dut (
        .clk(clk), .reset_n(reset_n), .en(en), .rx_byte(rx_byte), .rx_valid(rx_valid),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id), .cmd_len(cmd_len),
        .pl_raddr(pl_raddr), .pl_rdata(pl_rdata), .busy(busy), .clr_err(clr_err),
        .err_chk_cnt(err_chk_cnt), .err_len_cnt(err_len_cnt),
        .err_tmo_cnt(err_tmo_cnt), .err_ovr_cnt(err_ovr_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- reference model: frames as byte queues ----------------
    logic [7:0] q[$];
    logic [7:0] m_pl[16];
    bit         m_in, m_hold;
    int         m_gap, m_id, m_ln;
    int         m_chk, m_len, m_tmo, m_ovr;

    function automatic int sat(int c);
        return (c >= 255) ? 255 : c + 1;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_in = 0; m_hold = 0; q.delete(); m_gap = 0; m_id = 0; m_ln = 0;
            m_chk = 0; m_len = 0; m_tmo = 0; m_ovr = 0;
            for (int i = 0; i < 16; i++) m_pl[i] = 8'h00;
        end else begin
            if (m_hold) begin
                if (rx_valid)  m_ovr = sat(m_ovr);
                if (cmd_ready) m_hold = 0;
            end else if (m_in) begin
                if (!en) begin
                    m_in = 0;
                end else if (rx_valid) begin
                    q.push_back(rx_byte);
                    m_gap = 0;
                    if (q.size() == 2 && q[1] > 8'd16) begin
                        m_len = sat(m_len);
                        m_in  = 0;
                    end else if (q.size() >= 2 && q.size() == int'(q[1]) + 3) begin
                        logic [7:0] x;
                        x = 8'h00;
                        for (int i = 0; i < q.size() - 1; i++) x ^= q[i];
                        if (x == q[q.size()-1]) begin
                            m_hold = 1;
                            m_id   = int'(q[0]);
                            m_ln   = int'(q[1]);
                            for (int i = 0; i < m_ln; i++) m_pl[i] = q[i+2];
                        end else begin
                            m_chk = sat(m_chk);
                        end
                        m_in = 0;
                    end
                end else begin
                    m_gap++;
                    if (m_gap == 3500) begin
                        m_tmo = sat(m_tmo);
                        m_in  = 0;
                    end
                end
            end else if (rx_valid && en && rx_byte == 8'hAA) begin
                m_in = 1;
                q.delete();
                m_gap = 0;
            end
            if (clr_err) begin
                m_chk = 0; m_len = 0; m_tmo = 0; m_ovr = 0;
            end
        end
    end

    task automatic expect_eq(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (reset_n) begin
            expect_eq("m.busy", int'(busy), int'(m_in || m_hold));
            expect_eq("m.cmd_valid", int'(cmd_valid), int'(m_hold));
            expect_eq("m.err_chk", int'(err_chk_cnt), m_chk);
            expect_eq("m.err_len", int'(err_len_cnt), m_len);
            expect_eq("m.err_tmo", int'(err_tmo_cnt), m_tmo);
            expect_eq("m.err_ovr", int'(err_ovr_cnt), m_ovr);
            if (m_hold) begin
                expect_eq("m.cmd_id", int'(cmd_id), m_id);
                expect_eq("m.cmd_len", int'(cmd_len), m_ln);
                if (int'(pl_raddr) < m_ln)
                    expect_eq("m.pl_rdata", int'(pl_rdata), int'(m_pl[pl_raddr]));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic sb(input logic [7:0] b);
        rx_byte = b; rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic accept();
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; en = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00;
        cmd_ready = 1'b0; clr_err = 1'b0; pl_raddr = 4'd0;
        repeat (2) @(negedge clk);
        expect_eq("rst.cmd_valid", int'(cmd_valid), 0);
        expect_eq("rst.busy", int'(busy), 0);
        expect_eq("rst.cmd_id", int'(cmd_id), 0);
        expect_eq("rst.cmd_len", int'(cmd_len), 0);
        expect_eq("rst.pl_rdata", int'(pl_rdata), 0);
        expect_eq("rst.err_ovr", int'(err_ovr_cnt), 0);
        reset_n = 1'b1;
        @(negedge clk);

        // 1: good frame, checksum 10^03^01^02^04 = 14
        sb(8'hAA); sb(8'h10); sb(8'h03); sb(8'h01); sb(8'h02); sb(8'h04);
        expect_eq("t1.pre_chk_valid", int'(cmd_valid), 0);
        sb(8'h14);
        expect_eq("t1.cmd_valid", int'(cmd_valid), 1);
        expect_eq("t1.cmd_id", int'(cmd_id), 8'h10);
        expect_eq("t1.cmd_len", int'(cmd_len), 3);
        for (int i = 0; i < 3; i++) begin
            logic [7:0] expv[3];
            expv = '{8'h01, 8'h02, 8'h04};
            pl_raddr = 4'(i); #1;
            expect_eq("t1.payload", int'(pl_rdata), int'(expv[i]));
        end
        @(negedge clk);
        accept();
        expect_eq("t1.valid_drop", int'(cmd_valid), 0);
        expect_eq("t1.idle", int'(busy), 0);

        // 2: zero-length good frame, then bad checksum
        sb(8'hAA); sb(8'h5A); sb(8'h00); sb(8'h5A);
        expect_eq("t2.zl_valid", int'(cmd_valid), 1);
        expect_eq("t2.zl_len", int'(cmd_len), 0);
        accept();
        sb(8'hAA); sb(8'h5A); sb(8'h00); sb(8'h00);
        expect_eq("t2.bad_valid", int'(cmd_valid), 0);
        expect_eq("t2.err_chk", int'(err_chk_cnt), 1);

        // 3: oversize LEN, then noise before a good frame
        sb(8'hAA); sb(8'h01); sb(8'h11);
        expect_eq("t3.err_len", int'(err_len_cnt), 1);
        expect_eq("t3.idle", int'(busy), 0);
        sb(8'h00); sb(8'hAA); sb(8'h10); sb(8'h00); sb(8'h10);
        expect_eq("t3.valid", int'(cmd_valid), 1);
        expect_eq("t3.cmd_id", int'(cmd_id), 8'h10);
        accept();

        // 4: timeout after 3500 idle cycles; byte on the expiry cycle survives
        sb(8'hAA); sb(8'h10);
        repeat (3499) @(negedge clk);
        expect_eq("t4.still_busy", int'(busy), 1);
        @(negedge clk);
        expect_eq("t4.tmo_idle", int'(busy), 0);
        expect_eq("t4.err_tmo", int'(err_tmo_cnt), 1);
        sb(8'hAA); sb(8'h10);
        repeat (3499) @(negedge clk);
        sb(8'h03);
        expect_eq("t4.edge_busy", int'(busy), 1);
        expect_eq("t4.edge_tmo", int'(err_tmo_cnt), 1);

        // 6a: en dropped while in DATA
        sb(8'h01);
        en = 1'b0;
        @(negedge clk);
        en = 1'b1;
        expect_eq("t6.en_idle", int'(busy), 0);
        expect_eq("t6.en_chk", int'(err_chk_cnt), 1);
        expect_eq("t6.en_len", int'(err_len_cnt), 1);
        expect_eq("t6.en_tmo", int'(err_tmo_cnt), 1);

        // 5: overrun in HOLD, checksum 20^01^77 = 56
        sb(8'hAA); sb(8'h20); sb(8'h01); sb(8'h77); sb(8'h56);
        sb(8'hAA); sb(8'hAA); sb(8'h13);
        expect_eq("t5.ovr3", int'(err_ovr_cnt), 3);
        expect_eq("t5.cmd_id", int'(cmd_id), 8'h20);
        expect_eq("t5.still_valid", int'(cmd_valid), 1);
        cmd_ready = 1'b1;
        sb(8'hAA);
        cmd_ready = 1'b0;
        expect_eq("t5.ovr_hs", int'(err_ovr_cnt), 4);
        expect_eq("t5.no_frame", int'(busy), 0);
        sb(8'hAA); sb(8'h20); sb(8'h01); sb(8'h77); sb(8'h56);
        for (int i = 0; i < 260; i++) sb(8'(i));
        expect_eq("t5.sat", int'(err_ovr_cnt), 255);
        clr_err = 1'b1;
        sb(8'h55);
        clr_err = 1'b0;
        expect_eq("t5.clr_ovr", int'(err_ovr_cnt), 0);
        expect_eq("t5.clr_chk", int'(err_chk_cnt), 0);

        // 6b: reset while holding a command
        expect_eq("t6.hold_valid", int'(cmd_valid), 1);
        #2 reset_n = 1'b0;
        #1;
        expect_eq("t6.rst_valid", int'(cmd_valid), 0);
        expect_eq("t6.rst_busy", int'(busy), 0);
        expect_eq("t6.rst_cmd_id", int'(cmd_id), 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
